// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared defaults and helpers for the button debouncer family.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat press strobes).
// No ports; imported by debounce_chan and multi_debounce.
package debounce_pkg;

    localparam int unsigned DEB_ON_COUNT     = 4;
    localparam int unsigned DEB_OFF_COUNT    = 4;
    localparam int unsigned DEB_SYNC_STAGES  = 2;
    localparam int unsigned DEB_REPEAT_DELAY = 16;
    localparam int unsigned DEB_REPEAT_RATE  = 4;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
// One debounce channel: input synchroniser, sample counter with separate
// assert/release thresholds, registered level and one-cycle strobes.
// With DEBOUNCE_REPEAT_EN defined, press also auto-repeats while held.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   pulse   in   sample tick, one clk wide
//   button  in   raw asynchronous button level
//   yes     out  debounced level (registered)
//   press   out  one-cycle strobe on assertion (and auto-repeat)
//   unpress out  one-cycle strobe on deassertion
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned ON_COUNT     = DEB_ON_COUNT,
    parameter int unsigned OFF_COUNT    = DEB_OFF_COUNT,
    parameter int unsigned CNT_W        = 3,
`ifdef DEBOUNCE_REPEAT_EN
    parameter int unsigned REPEAT_DELAY = DEB_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEB_REPEAT_RATE,
`endif
    parameter int unsigned SYNC_STAGES  = DEB_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    input  logic button,
    output logic yes,
    output logic press,
    output logic unpress
);

    localparam logic [CNT_W:0] ON_TH  = (CNT_W + 1)'(ON_COUNT);
    localparam logic [CNT_W:0] OFF_TH = (CNT_W + 1)'(OFF_COUNT);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W:0]         cnt_inc;
    logic                   toggle;
    logic                   rpt_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync[0] <= button;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign s       = sync[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign toggle  = pulse && (s != yes) && (cnt_inc == (yes ? OFF_TH : ON_TH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            yes     <= 1'b0;
            press   <= 1'b0;
            unpress <= 1'b0;
        end else begin
            press   <= rpt_fire;
            unpress <= 1'b0;
            if (pulse) begin
                if (s == yes) begin
                    cnt <= '0;
                end else if (toggle) begin
                    cnt     <= '0;
                    yes     <= ~yes;
                    press   <= ~yes;
                    unpress <= yes;
                end else begin
                    cnt <= cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned          RPT_W    = cnt_width(REPEAT_DELAY);
    localparam logic [RPT_W:0]       RPT_TH   = (RPT_W + 1)'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]     RPT_LOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RPT_W-1:0] rpt;
    logic [RPT_W:0]   rpt_inc;

    assign rpt_inc  = {1'b0, rpt} + (RPT_W + 1)'(1);
    // A deasserting tick never repeats, so unpress and press cannot coincide.
    assign rpt_fire = pulse && yes && !toggle && (rpt_inc == RPT_TH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt <= '0;
        end else if (!yes || toggle) begin
            rpt <= '0;
        end else if (pulse) begin
            // Reload so the next fire comes REPEAT_RATE pulses later.
            rpt <= rpt_fire ? RPT_LOAD : rpt_inc[RPT_W-1:0];
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
// multi_debounce
// N-channel button debouncer: one debounce_chan per button bit, shared
// sample tick. Holds elaboration-time parameter checks.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat press strobes).
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   pulse   in   sample tick, one clk wide
//   button  in   [CHANNELS] raw button levels
//   yes     out  [CHANNELS] debounced levels
//   press   out  [CHANNELS] assertion (and repeat) strobes
//   unpress out  [CHANNELS] deassertion strobes
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned ON_COUNT     = DEB_ON_COUNT,
    parameter int unsigned OFF_COUNT    = DEB_OFF_COUNT,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned SYNC_STAGES  = DEB_SYNC_STAGES,
    parameter int unsigned REPEAT_DELAY = DEB_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEB_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pulse,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] yes,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] unpress
);

    localparam int unsigned MAX_COUNT = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;

    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_debounce: CHANNELS must be >= 1");
    end
    if (ON_COUNT < 1 || OFF_COUNT < 1) begin : g_bad_counts
        $error("multi_debounce: ON_COUNT and OFF_COUNT must be >= 1");
    end
    if (CNT_W < cnt_width(MAX_COUNT)) begin : g_bad_cnt_w
        $error("multi_debounce: CNT_W too narrow for max(ON_COUNT, OFF_COUNT)");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("multi_debounce: SYNC_STAGES must be >= 1");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
        $error("multi_debounce: REPEAT_RATE must be in 1..REPEAT_DELAY");
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        debounce_chan #(
            .ON_COUNT     (ON_COUNT),
            .OFF_COUNT    (OFF_COUNT),
            .CNT_W        (CNT_W),
`ifdef DEBOUNCE_REPEAT_EN
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
`endif
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .pulse   (pulse),
            .button  (button[i]),
            .yes     (yes[i]),
            .press   (press[i]),
            .unpress (unpress[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce
// Directed scoreboard bench for multi_debounce (CHANNELS=2, ON/OFF=4,
// SYNC_STAGES=2). Expected strobe events are queued by the stimulus; a
// negedge monitor pops one entry per observed strobe cycle.
// Repeat scenario runs only when DEBOUNCE_REPEAT_EN is defined.
module tb_multi_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic [1:0] button = 2'b00;
    logic [1:0] yes, press, unpress;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] p;
        logic [1:0] u;
        logic [1:0] y;
    } exp_t;

    exp_t exp_q[$];

    multi_debounce #(
        .CHANNELS     (2),
        .ON_COUNT     (4),
        .OFF_COUNT    (4),
        .CNT_W        (3),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse   (pulse),
        .button  (button),
        .yes     (yes),
        .press   (press),
        .unpress (unpress)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] p, input logic [1:0] u, input logic [1:0] y);
        exp_t e;
        e.p = p;
        e.u = u;
        e.y = y;
        exp_q.push_back(e);
    endtask

    // Leaves the caller 1 time unit after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        pulse = 1'b1;
        @(posedge clk);
        #1;
        pulse = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (press != 2'b00 || unpress != 2'b00)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got press=%b unpress=%b yes=%b expected none",
                         press, unpress, yes);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({press, unpress, yes} !== {e.p, e.u, e.y}) begin
                    errors++;
                    $display("FAIL strobe: got press=%b unpress=%b yes=%b expected press=%b unpress=%b yes=%b",
                             press, unpress, yes, e.p, e.u, e.y);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

`ifdef DEBOUNCE_REPEAT_EN
    function automatic bit rep_at(input int k);
        return (k >= 8) && (((k - 8) % 2) == 0);
    endfunction
`endif

    initial begin
        // Reset held with buttons high and pulses running.
        button = 2'b11;
        pulse  = 1'b1;
        rst    = 1'b1;
        cyc(6);
        check("reset_yes", 32'(yes), 32'h0);
        check("reset_press", 32'(press), 32'h0);
        check("reset_unpress", 32'(unpress), 32'h0);
        pulse = 1'b0;
        rst   = 1'b0;
        cyc(3);
        ticks(3);
        check("post_reset_3_ticks", 32'(yes), 32'h0);
        push(2'b11, 2'b00, 2'b11);
        tick();
        check("post_reset_assert", 32'(yes), 32'h3);

        // Release both together: simultaneous unpress strobes.
        button = 2'b00;
        cyc(3);
        ticks(3);
        check("release_both_3", 32'(yes), 32'h3);
        push(2'b00, 2'b11, 2'b00);
        tick();
        check("release_both", 32'(yes), 32'h0);

        // Assert channel 0 only.
        button = 2'b01;
        cyc(3);
        ticks(3);
        check("assert0_3", 32'(yes), 32'h0);
        push(2'b01, 2'b00, 2'b01);
        tick();
        check("assert0", 32'(yes), 32'h1);
        ticks(3);
        check("assert0_hold", 32'(yes), 32'h1);

        // Release channel 0.
        button = 2'b00;
        cyc(3);
        ticks(3);
        check("release0_3", 32'(yes), 32'h1);
        push(2'b00, 2'b01, 2'b00);
        tick();
        check("release0", 32'(yes), 32'h0);

        // Bounce: 1,1,1,0,1,1,1,1 -> assert only on the 8th tick.
        begin
            logic [7:0] samples;
            samples = 8'b1111_0111;
            for (int i = 0; i < 8; i++) begin
                button = {1'b0, samples[i]};
                cyc(3);
                if (i == 7) begin
                    check("bounce_before_8", 32'(yes), 32'h0);
                    push(2'b01, 2'b00, 2'b01);
                end
                tick();
            end
            check("bounce_assert", 32'(yes), 32'h1);
        end
        button = 2'b00;
        cyc(3);
        ticks(3);
        push(2'b00, 2'b01, 2'b00);
        tick();
        check("bounce_release", 32'(yes), 32'h0);

        // Glitches only between ticks: nothing may happen.
        for (int i = 0; i < 20; i++) begin
            button = 2'b01;
            cyc(1);
            button = 2'b00;
            cyc(3);
            tick();
        end
        check("glitch_yes", 32'(yes), 32'h0);

        // Reset mid-count discards progress.
        button = 2'b01;
        cyc(3);
        ticks(3);
        rst = 1'b1;
        cyc(2);
        check("midreset_yes", 32'(yes), 32'h0);
        rst = 1'b0;
        cyc(3);
        ticks(3);
        check("midreset_3", 32'(yes), 32'h0);
        push(2'b01, 2'b00, 2'b01);
        tick();
        check("midreset_assert", 32'(yes), 32'h1);

`ifdef DEBOUNCE_REPEAT_EN
        // Channel 0 already asserted 1 tick... restart cleanly for repeat timing.
        button = 2'b00;
        cyc(3);
        ticks(3);
        push(2'b00, 2'b01, 2'b00);
        tick();
        button = 2'b01;
        cyc(3);
        ticks(3);
        push(2'b01, 2'b00, 2'b01);
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (rep_at(k)) push(2'b01, 2'b00, 2'b01);
            tick();
        end
        button = 2'b00;
        cyc(3);
        for (int k = 21; k <= 24; k++) begin
            if (k == 24) push(2'b00, 2'b01, 2'b00);
            else if (rep_at(k)) push(2'b01, 2'b00, 2'b01);
            tick();
        end
        ticks(6);
        check("repeat_release", 32'(yes), 32'h0);
`else
        button = 2'b00;
        cyc(3);
        ticks(3);
        push(2'b00, 2'b01, 2'b00);
        tick();
        check("release_after_midreset", 32'(yes), 32'h0);
`endif

        // Pulse held high: every cycle samples; channel 1 asserts then releases.
        push(2'b10, 2'b00, 2'b10);
        button = 2'b10;
        pulse  = 1'b1;
        cyc(10);
        pulse = 1'b0;
        check("cont_assert", 32'(yes), 32'h2);
        push(2'b00, 2'b10, 2'b00);
        button = 2'b00;
        pulse  = 1'b1;
        cyc(10);
        pulse = 1'b0;
        check("cont_release", 32'(yes), 32'h0);

        cyc(5);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
